// File: rtl/booth_mul_iter.sv
// booth_mul_iter: iterative radix-4 Booth multiplier sequencer for the EX-stage
// 32x32 multiply path. Each BUSY cycle it presents one Booth group plus the
// four pre-shifted multiplicand variants to an external partial-product
// selector. It folds the selector's combinational answer into a 64-bit
// accumulator. After 17 groups the product is offered on a valid/ready port.
module booth_mul_iter #(
  parameter int N_GROUPS = 17,
  parameter int STEP_W   = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic        mul_signed,
  input  logic [31:0] mul_x,
  input  logic [31:0] mul_y,
  input  logic        cancel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] result,
  output logic [4:0]  exponent,
  output logic [2:0]  y_2_0,
  output logic [63:0] x_ext,
  output logic [63:0] neg_x_ext,
  output logic [63:0] x_ext_mult2,
  output logic [63:0] neg_x_ext_mult2,
  input  logic [63:0] partial_product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_GROUPS - 1);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [63:0]       acc_q, acc_d;
  // Multiplicand, sign/zero extended to 64 bits, shifted left 2 per group
  logic [63:0]       mreg_q, mreg_d;
  // Multiplier {ext, ext, y, y[-1]=0}, shifted right 2 per group
  logic [34:0]       yreg_q, yreg_d;
  logic              mul_ready_q, mul_ready_d;
  logic              res_valid_q, res_valid_d;

  logic              busy;
  logic              x_ext_bit;
  logic              y_ext_bit;
  logic [63:0]       neg_m;

  assign busy      = (state_q == BUSY);
  assign x_ext_bit = mul_signed & mul_x[31];
  assign y_ext_bit = mul_signed & mul_y[31];
  assign neg_m     = ~mreg_q + 64'd1;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    mreg_d  = mreg_q;
    yreg_d  = yreg_q;

    if (cancel) begin
      // Flush wins over everything, including a same-cycle request
      state_d = IDLE;
      step_d  = '0;
      acc_d   = '0;
      mreg_d  = '0;
      yreg_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mul_valid) begin
            state_d = BUSY;
            step_d  = '0;
            acc_d   = '0;
            mreg_d  = {{32{x_ext_bit}}, mul_x};
            yreg_d  = {{2{y_ext_bit}}, mul_y, 1'b0};
          end
        end
        BUSY: begin
          // Logical right shift is safe: by group 16 only {ext,ext,y31}
          // remain, which are already the correct top group bits.
          acc_d  = acc_q + partial_product;
          mreg_d = mreg_q << 2;
          yreg_d = yreg_q >> 2;
          step_d = step_q + STEP_W'(1);
          if (step_q == LAST_STEP) state_d = DONE;
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    mul_ready_d = (state_d == IDLE);
    res_valid_d = (state_d == DONE);
  end

  // Sequencer state and handshake outputs, async active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      step_q      <= '0;
      acc_q       <= '0;
      mreg_q      <= '0;
      yreg_q      <= '0;
      mul_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      mreg_q      <= mreg_d;
      yreg_q      <= yreg_d;
      mul_ready_q <= mul_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Selector drive: zero outside BUSY so the selector returns 0
  always_comb begin
    y_2_0           = 3'b000;
    x_ext           = '0;
    neg_x_ext       = '0;
    x_ext_mult2     = '0;
    neg_x_ext_mult2 = '0;
    if (busy) begin
      y_2_0           = yreg_q[2:0];
      x_ext           = mreg_q;
      neg_x_ext       = neg_m;
      x_ext_mult2     = mreg_q << 1;
      neg_x_ext_mult2 = neg_m << 1;
    end
  end

  assign mul_ready = mul_ready_q;
  assign res_valid = res_valid_q;
  assign result    = acc_q;
  assign exponent  = 5'd0;

endmodule
